// File: rtl/dcache_pkg.sv
// Shared width helpers and FSM state encoding for the dcache port arbiter.
package dcache_pkg;

  function automatic int aw_of(input int logcnt);
    return 10 + logcnt;
  endfunction

  function automatic int sw_of(input int logcnt);
    return 10 + logcnt - 1;
  endfunction

  function automatic int dw_of(input int bits, input int sz);
    return bits * sz * sz;
  endfunction

  localparam int SZ_DEF     = 4;
  localparam int LOGCNT_DEF = 5;
  localparam int BITS_DEF   = 18;
  localparam int AW_DEF     = aw_of(LOGCNT_DEF);
  localparam int SW_DEF     = sw_of(LOGCNT_DEF);
  localparam int DW_DEF     = dw_of(BITS_DEF, SZ_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker with last-winner pointer.
// DCACHE_ARB_PRIO0_EN gives requester 0 fixed top priority outside the rotation.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   pos_s;
  logic [NREQ-1:0] cand_s;
  logic            found_s;

  // Pick the first requester after the pointer (optionally requester 0 first).
  always_comb begin
    gnt     = '0;
    idx     = '0;
    pos_s   = '0;
    found_s = 1'b0;
    cand_s  = req;
`ifdef DCACHE_ARB_PRIO0_EN
    if (req[0]) begin
      gnt[0]  = 1'b1;
      found_s = 1'b1;
    end else begin
      cand_s[0] = 1'b0;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      pos_s = IW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && cand_s[pos_s]) begin
        gnt[pos_s] = 1'b1;
        idx        = pos_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer remembers the last rotating winner; moves only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= IW'(NREQ - 1);
    end else if (advance) begin
`ifdef DCACHE_ARB_PRIO0_EN
      if (idx != '0) ptr_r <= idx;
`else
      ptr_r <= idx;
`endif
    end
  end

endmodule

// File: rtl/dcache_arbiter.sv
// Round-robin arbiter sharing the dcache strided-matrix port among NREQ requesters.
// Optional build macro: DCACHE_ARB_PRIO0_EN (requester 0 always wins when valid).
module dcache_arbiter
  import dcache_pkg::*;
#(
  parameter  int SZ     = 4,
  parameter  int LOGCNT = 5,
  parameter  int BITS   = 18,
  parameter  int NREQ   = 2,
  localparam int AW     = aw_of(LOGCNT),
  localparam int SW     = sw_of(LOGCNT),
  localparam int DW     = dw_of(BITS, SZ),
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*SW-1:0] req_stride_x,
  input  logic [NREQ*SW-1:0] req_stride_y,
  input  logic [NREQ*DW-1:0] req_dat_w,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_dat,
  output logic [AW-1:0]      mem_addr,
  output logic [SW-1:0]      mem_stride_x,
  output logic [SW-1:0]      mem_stride_y,
  output logic               mem_we,
  output logic [DW-1:0]      mem_dat_w,
  input  logic [DW-1:0]      mem_dat_r
);

  arb_state_e      state_r, state_s;
  logic [IW-1:0]   owner_r;
  logic [NREQ-1:0] gnt_s;
  logic [IW-1:0]   idx_s;
  logic            advance_s;

  logic [AW-1:0]   mem_addr_r;
  logic [SW-1:0]   mem_stride_x_r, mem_stride_y_r;
  logic            mem_we_r;
  logic [DW-1:0]   mem_dat_w_r, rsp_dat_r;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (advance_s),
    .gnt     (gnt_s),
    .idx     (idx_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next state, grant handshake and state-decoded completion pulse.
  always_comb begin
    state_s   = state_r;
    req_ready = '0;
    rsp_valid = '0;
    advance_s = 1'b0;
    case (state_r)
      IDLE: begin
        if ((|req_valid) && !reset) begin
          req_ready = gnt_s;
          advance_s = 1'b1;
          state_s   = ACCESS;
        end else begin
          state_s   = IDLE;
        end
      end
      ACCESS:  state_s = RESP;
      RESP: begin
        rsp_valid[owner_r] = 1'b1;
        state_s            = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Capture the winner's request, then the read tile one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r        <= '0;
      mem_addr_r     <= '0;
      mem_stride_x_r <= '0;
      mem_stride_y_r <= '0;
      mem_we_r       <= 1'b0;
      mem_dat_w_r    <= '0;
      rsp_dat_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (advance_s) begin
            owner_r        <= idx_s;
            mem_addr_r     <= req_addr[int'(idx_s)*AW +: AW];
            mem_stride_x_r <= req_stride_x[int'(idx_s)*SW +: SW];
            mem_stride_y_r <= req_stride_y[int'(idx_s)*SW +: SW];
            mem_we_r       <= req_we[idx_s];
            mem_dat_w_r    <= req_dat_w[int'(idx_s)*DW +: DW];
          end
        end
        ACCESS: begin
          if (!mem_we_r) rsp_dat_r <= mem_dat_r;
          mem_we_r <= 1'b0;
        end
        default: begin
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr     = mem_addr_r;
  assign mem_stride_x = mem_stride_x_r;
  assign mem_stride_y = mem_stride_y_r;
  assign mem_we       = mem_we_r;
  assign mem_dat_w    = mem_dat_w_r;
  assign rsp_dat      = rsp_dat_r;

endmodule
